// File: rtl/sram_mem_bridge.sv
// sram_mem_bridge: native CPU memory bus to single-port SRAM macro bridge
// with base-address range check and configurable macro read latency.
module sram_mem_bridge #(
  parameter int ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic                  mem_instr,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic                  mem_err,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [3:0]            sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_din,
  input  logic [31:0]           sram_dout
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state;
  logic [2:0] cnt;
  logic rd, oor, in_range, unused_ok;
  assign in_range = mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
  assign unused_ok = ^{mem_instr, mem_addr[1:0]};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rd <= 1'b0;
      oor <= 1'b0;
      mem_ready <= 1'b0;
      mem_err <= 1'b0;
      mem_rdata <= '0;
      sram_csb <= 1'b1;
      sram_web <= 1'b1;
      sram_wmask <= '0;
      sram_addr <= '0;
      sram_din <= '0;
    end else begin
      mem_ready <= 1'b0;
      mem_err <= 1'b0;
      case (state)
        IDLE: if (mem_valid) begin
          state <= ISSUE;
          rd <= mem_wstrb == 4'b0;
          oor <= !in_range;
          if (in_range) begin
            sram_csb <= 1'b0;
            sram_web <= mem_wstrb == 4'b0;
            sram_wmask <= mem_wstrb;
            sram_addr <= mem_addr[ADDR_WIDTH+1:2];
            sram_din <= mem_wdata;
          end
        end
        ISSUE: begin
          sram_csb <= 1'b1;
          sram_web <= 1'b1;
          sram_wmask <= '0;
          cnt <= '0;
          if (rd && !oor) state <= WAIT;
          else begin
            state <= DONE;
            mem_ready <= 1'b1;
            mem_err <= oor;
            if (oor) mem_rdata <= '0;
          end
        end
        // the macro sampled on the ISSUE-exit edge; data lands READ_LATENCY edges later
        WAIT: if (cnt == 3'(READ_LATENCY - 1)) begin
          state <= DONE;
          mem_ready <= 1'b1;
          mem_rdata <= sram_dout;
          cnt <= '0;
        end else cnt <= cnt + 3'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sram_mem_bridge.sv
// tb_sram_mem_bridge: directed table-driven bench, latency-1 and latency-3 bridges
// against small behavioural SRAM macro models.
module tb_sram_mem_bridge;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic a_valid = 1'b0, a_instr = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic [3:0] a_wstrb = '0;
  logic a_ready, a_err, a_csb, a_web;
  logic [31:0] a_rdata, a_din, a_dout;
  logic [3:0] a_wmask;
  logic [7:0] a_saddr;

  logic b_valid = 1'b0, b_instr = 1'b1;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic [3:0] b_wstrb = '0;
  logic b_ready, b_err, b_csb, b_web;
  logic [31:0] b_rdata, b_din, b_dout;
  logic [3:0] b_wmask;
  logic [7:0] b_saddr;

  sram_mem_bridge #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0), .READ_LATENCY(1)) u_a (
    .clk(clk), .reset(reset), .mem_valid(a_valid), .mem_instr(a_instr), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_wstrb(a_wstrb), .mem_ready(a_ready), .mem_rdata(a_rdata),
    .mem_err(a_err), .sram_csb(a_csb), .sram_web(a_web), .sram_wmask(a_wmask),
    .sram_addr(a_saddr), .sram_din(a_din), .sram_dout(a_dout));

  sram_mem_bridge #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0), .READ_LATENCY(3)) u_b (
    .clk(clk), .reset(reset), .mem_valid(b_valid), .mem_instr(b_instr), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .mem_wstrb(b_wstrb), .mem_ready(b_ready), .mem_rdata(b_rdata),
    .mem_err(b_err), .sram_csb(b_csb), .sram_web(b_web), .sram_wmask(b_wmask),
    .sram_addr(b_saddr), .sram_din(b_din), .sram_dout(b_dout));

  // latency-1 macro: writable array, garbage on dout unless a read was sampled
  logic [31:0] a_mem [256];
  logic [31:0] a_pipe;
  assign a_dout = a_pipe;
  always @(posedge clk)
    if (reset) begin
      for (int i = 0; i < 256; i++) a_mem[i] <= (i == 4) ? 32'hCAFE_F00D : {4{8'(i)}};
      a_pipe <= 32'hDEAD_BEEF;
    end else begin
      a_pipe <= (!a_csb && a_web) ? a_mem[a_saddr] : 32'hDEAD_BEEF;
      if (!a_csb && !a_web)
        for (int j = 0; j < 4; j++) if (a_wmask[j]) a_mem[a_saddr][8*j +: 8] <= a_din[8*j +: 8];
    end

  // latency-3 macro: read-only pattern, three-stage data pipeline
  logic [31:0] b_p1, b_p2, b_p3;
  int b_acc = 0, b_nready = 0;
  assign b_dout = b_p3;
  always @(posedge clk) begin
    b_p1 <= (!b_csb && b_web) ? {24'hA5A5A5, b_saddr} : 32'hDEAD_BEEF;
    b_p2 <= b_p1;
    b_p3 <= b_p2;
    if (!reset && !b_csb) b_acc <= b_acc + 1;
    if (!reset && b_ready) b_nready <= b_nready + 1;
  end

  int n_pass = 0, n_tot = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", name, got, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic [31:0] addr, wdata;
    logic [3:0] wstrb;
    int lat;
    logic [31:0] rdata;
    logic err;
    int acc;
    logic [7:0] saddr;
    logic web;
    logic [3:0] wmask;
    logic [31:0] din;
  } vec_t;
  localparam int NV = 10;
  vec_t v [NV];

  task automatic b_read(input logic [31:0] addr, input bit hold, output int k, output logic [31:0] r);
    bit got = 1'b0;
    b_addr = addr;
    b_wstrb = '0;
    b_valid = 1'b1;
    k = 0;
    r = 'x;
    while (!got && k < 30) begin
      @(posedge clk); #1; k++;
      if (b_ready) begin got = 1'b1; r = b_rdata; b_valid = hold; end
    end
  endtask

  initial begin
    int k, acc, n0;
    bit got;
    logic [31:0] r;
    logic e, s_web;
    logic [7:0] s_addr;
    logic [3:0] s_mask;
    logic [31:0] s_din;
    v[0] = '{32'h0000_0010, 32'h1111_1111, 4'b0000, 3, 32'hCAFE_F00D, 1'b0, 1, 8'h04, 1'b1, 4'b0000, 32'h1111_1111};
    v[1] = '{32'h0000_0023, 32'hAB00_0000, 4'b1000, 2, 32'hCAFE_F00D, 1'b0, 1, 8'h08, 1'b0, 4'b1000, 32'hAB00_0000};
    v[2] = '{32'h0000_0020, 32'h2222_2222, 4'b0000, 3, 32'hAB08_0808, 1'b0, 1, 8'h08, 1'b1, 4'b0000, 32'h2222_2222};
    v[3] = '{32'h0000_0400, 32'h0000_0000, 4'b0000, 2, 32'h0000_0000, 1'b1, 0, 8'h00, 1'b1, 4'b0000, 32'h0};
    v[4] = '{32'h0000_03FC, 32'h1122_3344, 4'b0101, 2, 32'h0000_0000, 1'b0, 1, 8'hFF, 1'b0, 4'b0101, 32'h1122_3344};
    v[5] = '{32'h0000_03FF, 32'h3333_3333, 4'b0000, 3, 32'hFF22_FF44, 1'b0, 1, 8'hFF, 1'b1, 4'b0000, 32'h3333_3333};
    v[6] = '{32'hFFFF_FFF0, 32'h5555_5555, 4'b1111, 2, 32'h0000_0000, 1'b1, 0, 8'h00, 1'b1, 4'b0000, 32'h0};
    v[7] = '{32'h0000_0014, 32'h0000_0000, 4'b0000, 3, 32'h0505_0505, 1'b0, 1, 8'h05, 1'b1, 4'b0000, 32'h0};
    v[8] = '{32'h0000_0040, 32'h0BAD_CAFE, 4'b1111, 2, 32'h0505_0505, 1'b0, 1, 8'h10, 1'b0, 4'b1111, 32'h0BAD_CAFE};
    v[9] = '{32'h0000_0042, 32'h4444_4444, 4'b0000, 3, 32'h0BAD_CAFE, 1'b0, 1, 8'h10, 1'b1, 4'b0000, 32'h4444_4444};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(a_ready), 32'h0);
    chk("rst_err", 32'(a_err), 32'h0);
    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_csb", 32'(a_csb), 32'h1);
    chk("rst_web", 32'(a_web), 32'h1);
    chk("rst_wmask", 32'(a_wmask), 32'h0);
    chk("rst_saddr", 32'(a_saddr), 32'h0);
    chk("rst_din", a_din, 32'h0);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_csb", {31'b0, a_csb, b_csb} , 32'h3);

    for (int i = 0; i < NV; i++) begin
      a_addr = v[i].addr;
      a_wdata = v[i].wdata;
      a_wstrb = v[i].wstrb;
      a_instr = i[0];
      a_valid = 1'b1;
      k = 0; acc = 0; got = 1'b0; r = 'x; e = 1'bx;
      s_addr = 'x; s_web = 1'bx; s_mask = 'x; s_din = 'x;
      while (!got && k < 20) begin
        @(posedge clk); #1; k++;
        if (!a_csb) begin acc++; s_addr = a_saddr; s_web = a_web; s_mask = a_wmask; s_din = a_din; end
        if (a_ready) begin got = 1'b1; r = a_rdata; e = a_err; a_valid = 1'b0; end
      end
      chk($sformatf("v%0d_latency", i), 32'(k), 32'(v[i].lat));
      chk($sformatf("v%0d_rdata", i), r, v[i].rdata);
      chk($sformatf("v%0d_err", i), 32'(e), 32'(v[i].err));
      chk($sformatf("v%0d_sram_access", i), 32'(acc), 32'(v[i].acc));
      if (v[i].acc != 0) begin
        chk($sformatf("v%0d_sram_addr", i), 32'(s_addr), 32'(v[i].saddr));
        chk($sformatf("v%0d_sram_web", i), 32'(s_web), 32'(v[i].web));
        chk($sformatf("v%0d_sram_wmask", i), 32'(s_mask), 32'(v[i].wmask));
        chk($sformatf("v%0d_sram_din", i), s_din, v[i].din);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_ready_pulse", i), {30'b0, a_ready, a_err}, 32'h0);
      chk($sformatf("v%0d_rdata_hold", i), a_rdata, v[i].rdata);
    end

    b_read(32'h0000_0030, 1'b1, k, r);
    chk("b2b_lat0", 32'(k), 32'd5);
    chk("b2b_data0", r, 32'hA5A5_A50C);
    b_read(32'h0000_0034, 1'b1, k, r);
    chk("b2b_gap1", 32'(k), 32'd6);
    chk("b2b_data1", r, 32'hA5A5_A50D);
    b_read(32'h0000_0038, 1'b0, k, r);
    chk("b2b_gap2", 32'(k), 32'd6);
    chk("b2b_data2", r, 32'hA5A5_A50E);
    repeat (8) @(posedge clk);
    #1;
    chk("b2b_ready_count", 32'(b_nready), 32'd3);
    chk("b2b_sram_access", 32'(b_acc), 32'd3);

    b_addr = 32'h0000_0044;
    b_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(b_ready), 32'h0);
    chk("mid_rst_csb", 32'(b_csb), 32'h1);
    chk("mid_rst_web", 32'(b_web), 32'h1);
    chk("mid_rst_wmask", 32'(b_wmask), 32'h0);
    chk("mid_rst_saddr", 32'(b_saddr), 32'h0);
    chk("mid_rst_rdata", b_rdata, 32'h0);
    n0 = b_nready;
    b_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_no_ready", 32'(b_nready), 32'(n0));
    b_read(32'h0000_0004, 1'b0, k, r);
    chk("post_rst_lat", 32'(k), 32'd5);
    chk("post_rst_data", r, 32'hA5A5_A501);
    chk("post_rst_access", 32'(b_acc), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/sram_mem_bridge.md
SRAM_MEM_BRIDGE -- requirements
Module: sram_mem_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, SRAM word-address width (256 x 32-bit words).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte base address, aligned to 4*2^ADDR_WIDTH.
REQ-003 SHALL have parameter READ_LATENCY, default 1, range 1-4, edges from macro sample edge to valid sram_dout.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 mem_valid  input  1  CPU native-bus request, held until mem_ready.
REQ-008 mem_instr  input  1  instruction-fetch qualifier; no effect on the access.
REQ-009 mem_addr  input  32  byte address.
REQ-010 mem_wdata  input  32  write data.
REQ-011 mem_wstrb  input  4  byte write strobes; 0 = read.
REQ-012 mem_ready  output  1  one-cycle completion pulse.
REQ-013 mem_rdata  output  32  read data, valid while mem_ready=1.
REQ-014 mem_err  output  1  one-cycle pulse, coincident with mem_ready, on out-of-range access.
REQ-015 sram_csb  output  1  macro chip select, active-low.
REQ-016 sram_web  output  1  macro write enable, active-low.
REQ-017 sram_wmask  output  4  macro byte mask.
REQ-018 sram_addr  output  ADDR_WIDTH  macro word address.
REQ-019 sram_din  output  32  macro write data.
REQ-020 sram_dout  input  32  macro read data.

Function
REQ-021 SHALL implement FSM IDLE, ISSUE, WAIT, DONE; every output SHALL be registered.
REQ-022 IDLE with mem_valid=1 at an edge SHALL capture addr/wdata/wstrb and go to ISSUE; IDLE with mem_valid=0 SHALL stay in IDLE.
REQ-023 Range check: in-range iff mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]; mem_addr[1:0] SHALL be ignored.
REQ-024 In-range accept edge SHALL set sram_csb=0, sram_addr=mem_addr[ADDR_WIDTH+1:2], sram_din=mem_wdata, sram_web=(mem_wstrb==0), sram_wmask=mem_wstrb for reads and writes.
REQ-025 ISSUE SHALL last exactly one cycle; the edge leaving ISSUE SHALL return sram_csb to 1, sram_web to 1, sram_wmask to 0.
REQ-026 Write, or out-of-range access: ISSUE -> DONE; mem_ready SHALL be high in the cycle after the ISSUE-exit edge (2 cycles after accept).
REQ-027 Out-of-range access SHALL never assert sram_csb; the completing cycle SHALL have mem_rdata=0 and mem_err=1.
REQ-028 Read: ISSUE -> WAIT; WAIT SHALL count READ_LATENCY-1 edges (0 for latency 1, so it passes directly) and then load mem_rdata from sram_dout while moving to DONE.
REQ-029 Read latency, accept edge to mem_ready high, SHALL be READ_LATENCY+2 cycles.
REQ-030 DONE SHALL hold mem_ready=1 for exactly one cycle, then return to IDLE.
REQ-031 IDLE SHALL ignore mem_valid during the DONE cycle, so a held mem_valid is not re-accepted.
REQ-032 mem_rdata SHALL hold its last read value outside read completions; writes SHALL leave it unchanged.
REQ-033 If mem_valid drops mid-transaction, the bridge SHALL still complete the transaction and pulse mem_ready; the SRAM access SHALL not be aborted.
REQ-034 Partial writes: sram_wmask SHALL equal mem_wstrb bit-for-bit; wdata byte lanes SHALL pass through unshifted.
REQ-035 Throughput SHALL be one outstanding transaction; no request SHALL be accepted until the FSM returns to IDLE.

Reset
REQ-036 reset=1 SHALL immediately force: state IDLE, mem_ready=0, mem_err=0, mem_rdata=0, sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0, WAIT counter=0.
REQ-037 Reset asserted mid-transaction SHALL abort it with no mem_ready pulse; the first request after release SHALL be accepted normally.

Verification
REQ-038 Read, READ_LATENCY=1: addr 0x0000_0010, sram_dout=0xCAFE_F00D -> csb low 1 cycle, sram_addr=4, web=1, mem_ready 3 cycles after accept, mem_rdata=0xCAFE_F00D.
REQ-039 Byte write: addr 0x0000_0023, wstrb 4'b1000, wdata 0xAB00_0000 -> sram_addr=8, web=0, wmask=1000, din=0xAB00_0000, mem_ready 2 cycles after accept, mem_rdata unchanged.
REQ-040 Out-of-range read of 0x0000_0400 -> csb stays 1, mem_ready=1 and mem_err=1 together, mem_rdata=0.
REQ-041 READ_LATENCY=3, back-to-back reads with mem_valid held across completion -> each read has 5-cycle latency, exactly one mem_ready per request, no duplicate SRAM access.
REQ-042 Reset pulsed during WAIT -> outputs at reset values immediately, no mem_ready; next read at 0x0000_0004 completes correctly.
